// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: memory-wait FSM, branch flush and load-use stall.
// Optional STALL_CNT_EN macro adds a 32-bit saturating stall-cycle counter output.
module hazard_stall_unit #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned WAIT_W   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] Rs1_D,
   input  logic [4:0] Rs2_D,
   input  logic [4:0] RD_E,
   input  logic       MemReadE,
   input  logic       PCSrcE,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       BubbleW,
`ifdef STALL_CNT_EN
   output logic [31:0] stall_cycles,
`endif
   output logic       mem_timeout
);

   localparam logic [0:0] RUN      = 1'b0;
   localparam logic [0:0] MEM_WAIT = 1'b1;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_SAT   = '1;

   logic [0:0]        state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_nxt;
   logic              mem_stall;
   logic              load_use;
   logic              timeout_set;

   // Next-state, wait counter and pipeline control decode
   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      mem_stall   = 1'b0;
      load_use    = 1'b0;
      timeout_set = 1'b0;
      StallF      = 1'b0;
      StallD      = 1'b0;
      StallE      = 1'b0;
      StallM      = 1'b0;
      FlushD      = 1'b0;
      FlushE      = 1'b0;
      BubbleW     = 1'b0;

      if (state == RUN) begin
         if (MemReqM && !MemReadyM) begin
            mem_stall = 1'b1;
            state_nxt = MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
         end
      end else begin
         if (!MemReadyM) begin
            mem_stall = 1'b1;
            if (wait_cnt != WAIT_SAT) begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end else begin
            state_nxt = RUN;
            wait_nxt  = '0;
         end
      end

      load_use    = MemReadE && (RD_E != 5'd0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
      timeout_set = mem_stall && (wait_nxt == WAIT_LIMIT);

      // Priority: memory stall, then branch flush (squashes the dependent op), then load-use
      if (!rst) begin
         if (mem_stall) begin
            StallF  = 1'b1;
            StallD  = 1'b1;
            StallE  = 1'b1;
            StallM  = 1'b1;
            BubbleW = 1'b1;
         end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end
      end
   end

   // State, wait counter and sticky timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (timeout_set) begin
            mem_timeout <= 1'b1;
         end
      end
   end

`ifdef STALL_CNT_EN
   // Saturating count of fetch-stall cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (StallF && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed scenarios plus random stimulus
// compared against a behavioural model of the stall/flush rules.
module tb_hazard_stall_unit;

   localparam int unsigned MAX_WAIT = 4;
   localparam int unsigned WAIT_W   = 8;

   logic       clk;
   logic       rst;
   logic [4:0] Rs1_D, Rs2_D, RD_E;
   logic       MemReadE, PCSrcE, MemReqM, MemReadyM;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW;
   logic       mem_timeout;
`ifdef STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif

   logic [6:0] outs;
   assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleW};

   hazard_stall_unit #(.MAX_WAIT(MAX_WAIT), .WAIT_W(WAIT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .Rs1_D      (Rs1_D),
      .Rs2_D      (Rs2_D),
      .RD_E       (RD_E),
      .MemReadE   (MemReadE),
      .PCSrcE     (PCSrcE),
      .MemReqM    (MemReqM),
      .MemReadyM  (MemReadyM),
      .StallF     (StallF),
      .StallD     (StallD),
      .StallE     (StallE),
      .StallM     (StallM),
      .FlushD     (FlushD),
      .FlushE     (FlushE),
      .BubbleW    (BubbleW),
`ifdef STALL_CNT_EN
      .stall_cycles (stall_cycles),
`endif
      .mem_timeout(mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: whether memory is being waited on, cycles waited, sticky timeout, stall total
   bit     m_waiting = 0;
   int     m_waited  = 0;
   bit     m_to      = 0;
   longint m_cnt     = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, compare against the model, then advance the model
   task automatic step(input bit r, input bit req, input bit rdy, input bit mre, input bit pcs,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      bit         stall;
      logic [6:0] exp;
      @(negedge clk);
      rst = r; MemReqM = req; MemReadyM = rdy; MemReadE = mre; PCSrcE = pcs;
      RD_E = rd; Rs1_D = rs1; Rs2_D = rs2;
      #1;
      stall = m_waiting ? !rdy : (req && !rdy);
      exp   = 7'b0;
      if (!r) begin
         if (stall)                                          exp = 7'b1111001;
         else if (pcs)                                       exp = 7'b0000110;
         else if (mre && rd != 0 && (rd == rs1 || rd == rs2)) exp = 7'b1100010;
      end
      check_val("outs", 32'(outs), 32'(exp));
      check_val("mem_timeout", 32'(mem_timeout), 32'(m_to));
`ifdef STALL_CNT_EN
      check_val("stall_cycles", stall_cycles, m_cnt[31:0]);
`endif
      if (r) begin
         m_waiting = 0; m_waited = 0; m_to = 0; m_cnt = 0;
      end else begin
         if (exp[6] && m_cnt < 64'hFFFF_FFFF) m_cnt++;
         if (stall) begin
            m_waited  = m_waiting ? ((m_waited < 255) ? m_waited + 1 : 255) : 1;
            m_waiting = 1;
            if (m_waited == int'(MAX_WAIT)) m_to = 1;
         end else begin
            m_waiting = 0;
            m_waited  = 0;
         end
      end
   endtask

   initial begin
      rst = 1'b1; MemReqM = 0; MemReadyM = 0; MemReadE = 0; PCSrcE = 0;
      RD_E = 0; Rs1_D = 0; Rs2_D = 0;

      // Reset state
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 1, 1, 5, 5, 5);
      check_val("rst_outs", 32'(outs), 32'd0);

      // Load-use hazard, then x0 destination
      step(0, 0, 0, 1, 0, 5, 3, 5);
      check_val("lu_lit", 32'(outs), 32'(7'b1100010));
      step(0, 0, 0, 1, 0, 0, 0, 0);
      check_val("x0_lit", 32'(outs), 32'd0);

      // Branch overrides load-use
      step(0, 0, 0, 1, 1, 5, 3, 5);
      check_val("br_lit", 32'(outs), 32'(7'b0000110));

      // Memory wait of three cycles, release, then back in RUN
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 7, 7, 1);
      step(0, 0, 0, 1, 0, 7, 1, 7);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 1, 1, 5, 5, 5);
         check_val("mw_lit", 32'(outs), 32'(7'b1111001));
      end
      step(0, 1, 1, 0, 0, 0, 0, 0);
      check_val("mw_rel", 32'(outs), 32'd0);
`ifdef STALL_CNT_EN
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check_val("stall_cnt_5", stall_cycles, 32'd5);
`endif
      step(0, 0, 0, 0, 0, 0, 0, 0);

      // Timeout after the fourth wait edge, sticky past release until reset
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 6; i++) begin
         step(0, 1, 0, 0, 0, 0, 0, 0);
         if (i == 4) check_val("to_pre", 32'(mem_timeout), 32'd0);
         if (i == 5) check_val("to_set", 32'(mem_timeout), 32'd1);
      end
      step(0, 1, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check_val("to_sticky", 32'(mem_timeout), 32'd1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check_val("to_clr", 32'(mem_timeout), 32'd0);

      // Reset in the second wait cycle abandons the wait
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check_val("rst_wait", 32'(outs), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 4) == 0),
              5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, meaning the maximum memory-wait cycles before a timeout is flagged (legal 1..255).
REQ-002 SHALL have parameter WAIT_W, default 8, meaning the width of the memory-wait counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-005 SHALL have ports Rs1_D and Rs2_D, input, 5 each, meaning the decode-stage source register numbers.
REQ-006 SHALL have port RD_E, input, 5, meaning the execute-stage destination register.
REQ-007 SHALL have port MemReadE, input, 1, meaning a load is in the execute stage.
REQ-008 SHALL have port PCSrcE, input, 1, meaning a taken branch or jump was resolved in the execute stage.
REQ-009 SHALL have ports MemReqM and MemReadyM, input, 1 each, meaning a data-memory access is in the memory stage and memory has completed it.
REQ-010 SHALL have ports StallF, StallD, StallE and StallM, output, 1 each, meaning hold the corresponding pipeline register.
REQ-011 SHALL have ports FlushD, FlushE and BubbleW, output, 1 each, meaning clear the decode and execute registers and inject a NOP into writeback.
REQ-012 SHALL have port mem_timeout, output, 1, meaning a sticky memory-wait timeout flag.

Function
REQ-013 SHALL implement a two-state FSM, RUN and MEM_WAIT; all pipeline control outputs are combinational in the current state and inputs.
REQ-014 SHALL, in RUN with MemReqM=1 and MemReadyM=0, assert StallF, StallD, StallE, StallM and BubbleW, deassert both flushes, go to MEM_WAIT and load the wait counter with 1.
REQ-015 SHALL, in MEM_WAIT with MemReadyM=0, hold the same five outputs high and increment the wait counter, saturating at all-ones.
REQ-016 SHALL, in MEM_WAIT with MemReadyM=1, deassert all stalls and BubbleW that cycle, apply REQ-018/REQ-019 to the current inputs, return to RUN and clear the counter.
REQ-017 SHALL set mem_timeout on the edge where the wait counter reaches MAX_WAIT, and hold it until rst; the FSM keeps waiting.
REQ-018 SHALL detect a load-use hazard when there is no memory stall and MemReadE=1, RD_E!=0 and RD_E equals Rs1_D or Rs2_D.
REQ-019 SHALL respond to a load-use hazard by asserting StallF, StallD and FlushE for that cycle only.
REQ-020 SHALL, with no memory stall and PCSrcE=1, assert FlushD and FlushE, and SHALL suppress the load-use stall in that cycle because the dependent instruction is squashed.
REQ-021 SHALL apply the priority memory stall > branch flush > load-use stall.
REQ-022 SHALL, in RUN with no hazard and no branch, drive all outputs except mem_timeout to 0.
REQ-023 SHALL ignore RD_E=0 hazards, since x0 is never a hazard.
REQ-024 SHALL ignore PCSrcE and MemReadE during a memory stall, because the execute stage is frozen and re-presents them after release.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, force state RUN, counter 0, mem_timeout 0 and stall_cycles 0 (when present), regardless of state.
REQ-026 SHALL hold all stall, flush and BubbleW outputs at 0 while rst=1.
REQ-027 SHALL, on reset during MEM_WAIT, abandon the wait; the next cycle is in RUN.

Configuration
REQ-028 SHALL, with STALL_CNT_EN defined, add output stall_cycles, 32 bits, which increments on each clock edge where StallF=1 and rst=0, saturates at 0xFFFFFFFF and is cleared by rst.
REQ-029 SHALL, with STALL_CNT_EN undefined, omit the stall_cycles port and counter; all other behaviour is identical.

Verification
REQ-030 SHALL test load-use hazard: MemReadE=1, RD_E=5, Rs2_D=5 -> StallF=StallD=FlushE=1 for one cycle; with RD_E=0 -> all outputs 0.
REQ-031 SHALL test branch plus load-use: PCSrcE=1 with the REQ-030 load-use inputs -> FlushD=FlushE=1, StallF=StallD=0.
REQ-032 SHALL test memory wait: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> all stalls and BubbleW high for 3 cycles, all 0 on cycle 4, state RUN afterwards.
REQ-033 SHALL test timeout: with MAX_WAIT=4, hold MemReadyM=0 -> mem_timeout rises after the 4th wait edge and stays 1 after MemReadyM=1, until rst.
REQ-034 SHALL test reset mid-wait: rst=1 in MEM_WAIT cycle 2 -> next cycle all outputs 0, state RUN, mem_timeout 0.
REQ-035 SHALL test STALL_CNT_EN: 2 load-use cycles plus 3 memory-wait cycles -> stall_cycles=5.
